// File: rtl/mips_cpu_run_monitor.sv
// Watches the CPU status outputs during a test run and reports the result.
// It detects halt, captures v0, counts enabled cycles and fetches, and flags timeouts and restarts.
module mips_cpu_run_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned COUNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               clk_enable,
    input  logic               active,
    input  logic [31:0]        register_v0,
    input  logic [31:0]        instr_address,
    input  logic [31:0]        expected_v0,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic               error,
    output logic [31:0]        result_v0,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CMP_W  = 64;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE,
        S_TIMEOUT,
        S_ERROR
    } state_t;

    state_t            state;
    logic [31:0]       prev_addr;
    logic [WAIT_W-1:0] wait_cnt;

    logic rearm_c;
    logic run_limit_c;
    logic wait_limit_c;

    // Compare at a fixed wide width so a narrow counter never aliases the limit.
    assign run_limit_c  = (CMP_W'(cycle_count) == CMP_W'(TIMEOUT_CYCLES));
    assign wait_limit_c = (CMP_W'(wait_cnt) == CMP_W'(TIMEOUT_CYCLES));
    assign rearm_c      = start && (state != S_ARMED) && (state != S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            error       <= 1'b0;
            result_v0   <= 32'd0;
            cycle_count <= '0;
            fetch_count <= '0;
            prev_addr   <= 32'd0;
            wait_cnt    <= '0;
        end else if (rearm_c) begin
            // Start outranks everything outside ARMED/RUN, including a restart in DONE.
            state       <= S_ARMED;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            error       <= 1'b0;
            result_v0   <= 32'd0;
            cycle_count <= '0;
            fetch_count <= '0;
            prev_addr   <= 32'd0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_ARMED: begin
                    if (active) begin
                        state       <= S_RUN;
                        prev_addr   <= instr_address;
                        fetch_count <= COUNT_W'(1);
                    end else if (wait_limit_c) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end else if (clk_enable) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_RUN: begin
                    // Exit edges leave the counters untouched.
                    if (!active) begin
                        state     <= S_DONE;
                        result_v0 <= register_v0;
                        pass      <= (register_v0 == expected_v0);
                        done      <= 1'b1;
                    end else if (run_limit_c) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                    end else if (clk_enable) begin
                        if (cycle_count != COUNT_MAX) begin
                            cycle_count <= cycle_count + COUNT_W'(1);
                        end
                        if (instr_address != prev_addr) begin
                            prev_addr <= instr_address;
                            if (fetch_count != COUNT_MAX) begin
                                fetch_count <= fetch_count + COUNT_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (active) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                        pass  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Directed bench for mips_cpu_run_monitor: a main instance with a short timeout
// and a narrow-counter instance on the same stimulus to exercise saturation.
module tb_mips_cpu_run_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        clk_enable;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] instr_address;
    logic [31:0] expected_v0;

    logic        done, pass, timeout, error;
    logic [31:0] result_v0, cycle_count, fetch_count;

    logic        s_done, s_pass, s_timeout, s_error;
    logic [31:0] s_result_v0;
    logic [2:0]  s_cycle_count, s_fetch_count;

    int checks   = 0;
    int failures = 0;

    mips_cpu_run_monitor #(.TIMEOUT_CYCLES(50), .COUNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .clk_enable(clk_enable),
        .active(active), .register_v0(register_v0), .instr_address(instr_address),
        .expected_v0(expected_v0), .done(done), .pass(pass), .timeout(timeout),
        .error(error), .result_v0(result_v0), .cycle_count(cycle_count),
        .fetch_count(fetch_count)
    );

    mips_cpu_run_monitor #(.TIMEOUT_CYCLES(100), .COUNT_W(3)) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .clk_enable(clk_enable),
        .active(active), .register_v0(register_v0), .instr_address(instr_address),
        .expected_v0(expected_v0), .done(s_done), .pass(s_pass), .timeout(s_timeout),
        .error(s_error), .result_v0(s_result_v0), .cycle_count(s_cycle_count),
        .fetch_count(s_fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".pass"}, 64'(pass), 64'd0);
        chk({tag, ".timeout"}, 64'(timeout), 64'd0);
        chk({tag, ".error"}, 64'(error), 64'd0);
        chk({tag, ".result_v0"}, 64'(result_v0), 64'd0);
        chk({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        clk_enable    = 1'b0;
        active        = 1'b0;
        register_v0   = 32'd0;
        instr_address = 32'd0;
        expected_v0   = 32'd0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Test 1: arm edge, then 10 enabled RUN edges, then halt with matching v0.
        clk_enable = 1'b1;
        start = 1'b1;
        tick();
        start  = 1'b0;
        active = 1'b1;
        tick();
        repeat (10) tick();
        chk("t1.done_before_halt", 64'(done), 64'd0);
        chk("t1.cycles_before_halt", 64'(cycle_count), 64'd10);
        active      = 1'b0;
        register_v0 = 32'd24;
        expected_v0 = 32'd24;
        tick();
        chk("t1.done", 64'(done), 64'd1);
        chk("t1.pass", 64'(pass), 64'd1);
        chk("t1.result_v0", 64'(result_v0), 64'd24);
        chk("t1.cycle_count", 64'(cycle_count), 64'd10);
        chk("t1.fetch_count", 64'(fetch_count), 64'd1);

        // Test 2: same run, expected value differs.
        start = 1'b1;
        tick();
        start  = 1'b0;
        active = 1'b1;
        tick();
        repeat (10) tick();
        active      = 1'b0;
        expected_v0 = 32'd25;
        tick();
        chk("t2.done", 64'(done), 64'd1);
        chk("t2.pass", 64'(pass), 64'd0);
        chk("t2.result_v0", 64'(result_v0), 64'd24);
        chk("t2.timeout", 64'(timeout), 64'd0);
        chk("t2.error", 64'(error), 64'd0);

        // Start and active together in DONE: start wins, monitor re-arms.
        start  = 1'b1;
        active = 1'b1;
        tick();
        start = 1'b0;
        chk("rearm.done", 64'(done), 64'd0);
        chk("rearm.error", 64'(error), 64'd0);
        chk("rearm.result_v0", 64'(result_v0), 64'd0);

        // Test 4: enable toggles, address advances only on enabled edges.
        instr_address = 32'hBFC0_0000;
        tick();
        chk("t4.fetch_at_entry", 64'(fetch_count), 64'd1);
        for (int i = 0; i < 20; i++) begin
            clk_enable = (i % 2 == 0);
            if (clk_enable) instr_address = instr_address + 32'd4;
            tick();
        end
        chk("t4.cycle_count", 64'(cycle_count), 64'd10);
        chk("t4.fetch_count", 64'(fetch_count), 64'd11);
        chk("t4.sat_cycle_count", 64'(s_cycle_count), 64'd7);
        chk("t4.sat_fetch_count", 64'(s_fetch_count), 64'd7);
        chk("t4.sat_done", 64'(s_done), 64'd0);

        // Test 5: halt with a pass, then a restart turns it into ERROR.
        clk_enable  = 1'b1;
        expected_v0 = 32'd24;
        active      = 1'b0;
        tick();
        chk("t5.pass_at_halt", 64'(pass), 64'd1);
        active = 1'b1;
        tick();
        chk("t5.error", 64'(error), 64'd1);
        chk("t5.pass", 64'(pass), 64'd0);
        chk("t5.done", 64'(done), 64'd1);
        active = 1'b0;
        tick();
        chk("t5.error_sticky", 64'(error), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all_zero("t5.rearm");

        // Waiting in ARMED with no activity times out one edge after 50 enabled waits.
        repeat (50) tick();
        chk("armed.timeout_before", 64'(timeout), 64'd0);
        tick();
        chk("armed.timeout", 64'(timeout), 64'd1);
        chk("armed.done", 64'(done), 64'd1);
        chk("armed.pass", 64'(pass), 64'd0);

        // Test 3: RUN timeout; a start pulse mid-run is ignored.
        start = 1'b1;
        tick();
        start  = 1'b0;
        active = 1'b1;
        tick();
        repeat (25) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3.start_ignored", 64'(cycle_count), 64'd26);
        repeat (24) tick();
        chk("t3.cycles_at_limit", 64'(cycle_count), 64'd50);
        chk("t3.timeout_before", 64'(timeout), 64'd0);
        tick();
        chk("t3.timeout", 64'(timeout), 64'd1);
        chk("t3.done", 64'(done), 64'd1);
        chk("t3.pass", 64'(pass), 64'd0);
        chk("t3.cycle_count_held", 64'(cycle_count), 64'd50);

        // Test 6: asynchronous reset in the middle of RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (5) tick();
        chk("t6.cycles_before_reset", 64'(cycle_count), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("t6.async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("t6.idle_fetch", 64'(fetch_count), 64'd0);
        chk("t6.idle_done", 64'(done), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6.rearmed_fetch", 64'(fetch_count), 64'd1);
        repeat (3) tick();
        active      = 1'b0;
        register_v0 = 32'hFFFF_FFFF;
        expected_v0 = 32'hFFFF_FFFF;
        tick();
        chk("t6.pass", 64'(pass), 64'd1);
        chk("t6.result_v0", 64'(result_v0), 64'hFFFF_FFFF);
        chk("t6.cycle_count", 64'(cycle_count), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
